// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation stations.
//   WIDTH   : operand MSB index (32-bit data)
//   ROB     : ROB tag MSB index (8 tags)
//   A_WIDTH : ALUControl MSB index
//   rs_entry_t : one station slot (valid, busy/tag/value per operand, op, dest tag)
//   RS_ALU / RS_BRANCH : station codes carried by RSstation
package rs_pkg;

  localparam int unsigned WIDTH   = 31;
  localparam int unsigned ROB     = 2;
  localparam int unsigned A_WIDTH = 3;

  localparam logic [1:0] RS_ALU    = 2'b00;
  localparam logic [1:0] RS_BRANCH = 2'b01;

  typedef struct packed {
    logic             valid;
    logic             busy1;
    logic             busy2;
    logic [ROB:0]     rob1;
    logic [ROB:0]     rob2;
    logic [WIDTH:0]   op1;
    logic [WIDTH:0]   op2;
    logic [A_WIDTH:0] aluCtl;
    logic [ROB:0]     robDest;
  } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_if.sv
// Decode / CDB / issue bundle of the ALU reservation station.
//   slave  : the station (consumes requests and CDB, drives ALUFull and the issue register)
//   master : the environment (decode, CDB, ALU issue consumer)
interface alu_reservation_station_if;
  import rs_pkg::*;

  // Decode request
  logic             stationRequest;
  logic [1:0]       RSstation;
  logic [A_WIDTH:0] ALUControl;
  logic [WIDTH:0]   operand1;
  logic [WIDTH:0]   operand2;
  logic             busy1;
  logic             busy2;
  logic [ROB:0]     rob1;
  logic [ROB:0]     rob2;
  logic [ROB:0]     robInstr;
  logic             ALUFull;
  // Common data bus
  logic             cdbValid;
  logic [ROB:0]     cdbROB;
  logic [WIDTH:0]   cdbResult;
  // Issue register
  logic             issueReady;
  logic             issueValid;
  logic [WIDTH:0]   issueOp1;
  logic [WIDTH:0]   issueOp2;
  logic [A_WIDTH:0] issueALUControl;
  logic [ROB:0]     issueROB;

  modport slave (
    input  stationRequest, RSstation, ALUControl, operand1, operand2, busy1, busy2,
    input  rob1, rob2, robInstr, cdbValid, cdbROB, cdbResult, issueReady,
    output ALUFull, issueValid, issueOp1, issueOp2, issueALUControl, issueROB
  );

  modport master (
    output stationRequest, RSstation, ALUControl, operand1, operand2, busy1, busy2,
    output rob1, rob2, robInstr, cdbValid, cdbROB, cdbResult, issueReady,
    input  ALUFull, issueValid, issueOp1, issueOp2, issueALUControl, issueROB
  );

endinterface

// File: rtl/rs_select.sv
// Combinational issue picker for a reservation station.
//   ready_i : per-entry ready bits
//   age_i   : (RS_AGE_SELECT_EN only) age_i[i][j]=1 when entry i is older than entry j
//   grant_o : one-hot grant, idx_o : grant index, any_o : some entry is ready
// Default build grants the lowest-index ready entry; with RS_AGE_SELECT_EN the oldest.
module rs_select #(
  parameter int unsigned Entries = 4
) (
  input  logic [Entries-1:0]                      ready_i,
`ifdef RS_AGE_SELECT_EN
  input  logic [Entries-1:0][Entries-1:0]         age_i,
`endif
  output logic [Entries-1:0]                      grant_o,
  output logic [$clog2(Entries)-1:0]              idx_o,
  output logic                                    any_o
);

  localparam int unsigned IdxW = $clog2(Entries);

  logic [Entries-1:0] cand;

  always_comb begin
    cand = ready_i;
`ifdef RS_AGE_SELECT_EN
    // Drop any ready entry that has an older ready competitor.
    for (int i = 0; i < int'(Entries); i++) begin
      for (int j = 0; j < int'(Entries); j++) begin
        if (i != j && ready_i[i] && ready_i[j] && !age_i[i][j]) cand[i] = 1'b0;
      end
    end
`endif
    grant_o = '0;
    idx_o   = '0;
    for (int i = int'(Entries) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IdxW'(i);
      end
    end
    any_o = |ready_i;
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: accepts ALU ops from decode, snoops the CDB for pending
// operands, and issues one ready op per cycle through a valid/ready issue register.
//   clk, globalReset (sync, active high), flush (same effect as reset, highest priority)
//   rs_if : decode request + ALUFull, CDB, issue register (slave modport)
// Optional: define RS_AGE_SELECT_EN to issue the oldest ready entry instead of the
// lowest-index one (adds an ENTRIES x ENTRIES age matrix).
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  logic                        clk,
  input  logic                        globalReset,
  input  logic                        flush,
  alu_reservation_station_if.slave    rs_if
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned CntW = IdxW + 1;

  rs_entry_t        entry_q [ENTRIES];
  rs_entry_t        entry_d [ENTRIES];
  logic             issue_valid_q, issue_valid_d;
  logic [WIDTH:0]   issue_op1_q, issue_op1_d, issue_op2_q, issue_op2_d;
  logic [A_WIDTH:0] issue_ctl_q, issue_ctl_d;
  logic [ROB:0]     issue_rob_q, issue_rob_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [ENTRIES-1:0] valid_vec, ready_vec, grant;
  logic [IdxW-1:0]    sel_idx, alloc_idx;
  logic               any_ready, alu_full, accept, load_en, issue_load, hit1, hit2;
  rs_entry_t          new_entry;

  // Ready is derived from registered state only, so a CDB wakeup is never bypassed
  // into selection in the same cycle.
  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      valid_vec[i] = entry_q[i].valid;
      ready_vec[i] = entry_q[i].valid & ~entry_q[i].busy1 & ~entry_q[i].busy2;
    end
  end

  assign alu_full = &valid_vec;
  assign accept   = rs_if.stationRequest & (rs_if.RSstation == RS_ALU) & ~alu_full;

  // Lowest free slot; a slot being issued this edge still counts as occupied.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IdxW'(i);
    end
  end

`ifdef RS_AGE_SELECT_EN
  logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;

  // New entry is younger than every currently valid entry.
  always_comb begin
    age_d = age_q;
    if (accept) begin
      for (int j = 0; j < int'(ENTRIES); j++) begin
        age_d[alloc_idx][j] = 1'b0;
        age_d[j][alloc_idx] = valid_vec[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset || flush) age_q <= '0;
    else                      age_q <= age_d;
  end
`endif

  rs_select #(
    .Entries (ENTRIES)
  ) u_select (
    .ready_i (ready_vec),
`ifdef RS_AGE_SELECT_EN
    .age_i   (age_q),
`endif
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (any_ready)
  );

  // Incoming entry, with same-cycle CDB bypass on busy operands.
  always_comb begin
    hit1 = rs_if.cdbValid & rs_if.busy1 & (rs_if.rob1 == rs_if.cdbROB);
    hit2 = rs_if.cdbValid & rs_if.busy2 & (rs_if.rob2 == rs_if.cdbROB);
    new_entry.valid   = 1'b1;
    new_entry.busy1   = rs_if.busy1 & ~hit1;
    new_entry.busy2   = rs_if.busy2 & ~hit2;
    new_entry.rob1    = rs_if.rob1;
    new_entry.rob2    = rs_if.rob2;
    new_entry.op1     = hit1 ? rs_if.cdbResult : rs_if.operand1;
    new_entry.op2     = hit2 ? rs_if.cdbResult : rs_if.operand2;
    new_entry.aluCtl  = rs_if.ALUControl;
    new_entry.robDest = rs_if.robInstr;
  end

  assign load_en    = ~issue_valid_q | rs_if.issueReady;
  assign issue_load = load_en & any_ready;

  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid && rs_if.cdbValid) begin
        if (entry_q[i].busy1 && entry_q[i].rob1 == rs_if.cdbROB) begin
          entry_d[i].op1   = rs_if.cdbResult;
          entry_d[i].busy1 = 1'b0;
        end
        if (entry_q[i].busy2 && entry_q[i].rob2 == rs_if.cdbROB) begin
          entry_d[i].op2   = rs_if.cdbResult;
          entry_d[i].busy2 = 1'b0;
        end
      end
      if (issue_load && grant[i]) entry_d[i].valid = 1'b0;
    end
    if (accept) entry_d[alloc_idx] = new_entry;

    issue_valid_d = issue_valid_q;
    issue_op1_d   = issue_op1_q;
    issue_op2_d   = issue_op2_q;
    issue_ctl_d   = issue_ctl_q;
    issue_rob_d   = issue_rob_q;
    if (load_en) begin
      issue_valid_d = any_ready;
      if (any_ready) begin
        issue_op1_d = entry_q[sel_idx].op1;
        issue_op2_d = entry_q[sel_idx].op2;
        issue_ctl_d = entry_q[sel_idx].aluCtl;
        issue_rob_d = entry_q[sel_idx].robDest;
      end
    end

    count_d = count_q + CntW'(accept) - CntW'(issue_load);
  end

  always_ff @(posedge clk) begin
    if (globalReset || flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) entry_q[i] <= '0;
      issue_valid_q <= 1'b0;
      issue_op1_q   <= '0;
      issue_op2_q   <= '0;
      issue_ctl_q   <= '0;
      issue_rob_q   <= '0;
      count_q       <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) entry_q[i] <= entry_d[i];
      issue_valid_q <= issue_valid_d;
      issue_op1_q   <= issue_op1_d;
      issue_op2_q   <= issue_op2_d;
      issue_ctl_q   <= issue_ctl_d;
      issue_rob_q   <= issue_rob_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!globalReset) assert (count_q == CntW'($countones(valid_vec)));
  end

  assign rs_if.ALUFull         = alu_full;
  assign rs_if.issueValid      = issue_valid_q;
  assign rs_if.issueOp1        = issue_op1_q;
  assign rs_if.issueOp2        = issue_op2_q;
  assign rs_if.issueALUControl = issue_ctl_q;
  assign rs_if.issueROB        = issue_rob_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: single-instruction table plus
// hand sequences for wakeup, backpressure/full, flush and selection order.
module tb_alu_reservation_station;
  import rs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_reservation_station_if rs_if ();

  alu_reservation_station #(
    .ENTRIES (4)
  ) dut (
    .clk         (clk),
    .globalReset (rst),
    .flush       (flush),
    .rs_if       (rs_if)
  );

  typedef struct {
    logic        b1, b2;
    logic [2:0]  r1, r2;
    logic [31:0] o1, o2;
    logic [3:0]  ctl;
    logic [2:0]  rd;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cr;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic req(input logic b1, input logic b2, input logic [2:0] r1,
                     input logic [2:0] r2, input logic [31:0] o1, input logic [31:0] o2,
                     input logic [3:0] ctl, input logic [2:0] rd);
    rs_if.stationRequest = 1'b1;
    rs_if.RSstation      = RS_ALU;
    rs_if.busy1          = b1;
    rs_if.busy2          = b2;
    rs_if.rob1           = r1;
    rs_if.rob2           = r2;
    rs_if.operand1       = o1;
    rs_if.operand2       = o2;
    rs_if.ALUControl     = ctl;
    rs_if.robInstr       = rd;
  endtask

  task automatic cdb(input logic v, input logic [2:0] tag, input logic [31:0] res);
    rs_if.cdbValid  = v;
    rs_if.cdbROB    = tag;
    rs_if.cdbResult = res;
  endtask

  logic [2:0] first_rob;
  logic [2:0] drain [4];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 3'd0, 3'd0, 32'd5, 32'd7, 4'h0, 3'd3, 1'b0, 3'd0, 32'd0,
               32'd5, 32'd7};
    tbl[1] = '{1'b0, 1'b0, 3'd1, 3'd2, 32'hFFFF_FFFF, 32'd0, 4'hF, 3'd7, 1'b0, 3'd0, 32'd0,
               32'hFFFF_FFFF, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 3'd4, 3'd4, 32'd1, 32'd0, 4'h2, 3'd1, 1'b1, 3'd4, 32'd9,
               32'd1, 32'd9};
    tbl[3] = '{1'b1, 1'b1, 3'd2, 3'd2, 32'd0, 32'd0, 4'h5, 3'd6, 1'b1, 3'd2, 32'h1234,
               32'h1234, 32'h1234};
    tbl[4] = '{1'b0, 1'b0, 3'd5, 3'd6, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'hA, 3'd0, 1'b1, 3'd5,
               32'hBEEF, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

    rst = 1'b1;
    flush = 1'b0;
    rs_if.stationRequest = 1'b0;
    rs_if.RSstation = RS_ALU;
    rs_if.ALUControl = '0;
    rs_if.operand1 = '0;
    rs_if.operand2 = '0;
    rs_if.busy1 = 1'b0;
    rs_if.busy2 = 1'b0;
    rs_if.rob1 = '0;
    rs_if.rob2 = '0;
    rs_if.robInstr = '0;
    rs_if.issueReady = 1'b1;
    cdb(1'b0, 3'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(rs_if.issueValid), 32'd0);
    check("rst_full", 32'(rs_if.ALUFull), 32'd0);
    check("rst_op1", rs_if.issueOp1, 32'd0);
    check("rst_op2", rs_if.issueOp2, 32'd0);
    check("rst_ctl", 32'(rs_if.issueALUControl), 32'd0);
    check("rst_rob", 32'(rs_if.issueROB), 32'd0);

    // Other station code is ignored
    req(1'b0, 1'b0, 3'd0, 3'd0, 32'd1, 32'd2, 4'h1, 3'd2);
    rs_if.RSstation = RS_BRANCH;
    tick();
    rs_if.stationRequest = 1'b0;
    tick();
    tick();
    check("branch_ignored", 32'(rs_if.issueValid), 32'd0);

    // Single-instruction table: issue two edges after accept
    for (int i = 0; i < 5; i++) begin
      req(tbl[i].b1, tbl[i].b2, tbl[i].r1, tbl[i].r2, tbl[i].o1, tbl[i].o2, tbl[i].ctl,
          tbl[i].rd);
      cdb(tbl[i].cv, tbl[i].ct, tbl[i].cr);
      tick();
      rs_if.stationRequest = 1'b0;
      cdb(1'b0, 3'd0, 32'd0);
      check($sformatf("tbl%0d_early", i), 32'(rs_if.issueValid), 32'd0);
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(rs_if.issueValid), 32'd1);
      check($sformatf("tbl%0d_op1", i), rs_if.issueOp1, tbl[i].e1);
      check($sformatf("tbl%0d_op2", i), rs_if.issueOp2, tbl[i].e2);
      check($sformatf("tbl%0d_ctl", i), 32'(rs_if.issueALUControl), 32'(tbl[i].ctl));
      check($sformatf("tbl%0d_rob", i), 32'(rs_if.issueROB), 32'(tbl[i].rd));
    end
    tick();
    check("tbl_drop", 32'(rs_if.issueValid), 32'd0);

    // CDB wakeup after a 3-cycle wait, with a non-matching broadcast meanwhile
    req(1'b1, 1'b0, 3'd6, 3'd0, 32'd0, 32'd2, 4'h3, 3'd5);
    tick();
    rs_if.stationRequest = 1'b0;
    cdb(1'b1, 3'd2, 32'h7777);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wake_hold%0d", k), 32'(rs_if.issueValid), 32'd0);
    end
    cdb(1'b1, 3'd6, 32'hDEAD);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    check("wake_early", 32'(rs_if.issueValid), 32'd0);
    tick();
    check("wake_valid", 32'(rs_if.issueValid), 32'd1);
    check("wake_op1", rs_if.issueOp1, 32'hDEAD);
    check("wake_op2", rs_if.issueOp2, 32'd2);
    check("wake_rob", 32'(rs_if.issueROB), 32'd5);
    tick();

    // Full and backpressure
`ifdef RS_AGE_SELECT_EN
    first_rob = 3'd1;
    drain = '{3'd2, 3'd3, 3'd4, 3'd5};
`else
    first_rob = 3'd2;
    drain = '{3'd5, 3'd1, 3'd3, 3'd4};
`endif
    rs_if.issueReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill%0d_notfull", i), 32'(rs_if.ALUFull), 32'd0);
      req(1'b0, 1'b0, 3'd0, 3'd0, 32'(i + 10), 32'd0, 4'h0, 3'(i));
      tick();
    end
    check("full_set", 32'(rs_if.ALUFull), 32'd1);
    check("full_issue_valid", 32'(rs_if.issueValid), 32'd1);
    check("full_issue_rob", 32'(rs_if.issueROB), 32'd0);
    req(1'b0, 1'b0, 3'd0, 3'd0, 32'd15, 32'd0, 4'h0, 3'd5);
    tick();
    check("full_hold", 32'(rs_if.ALUFull), 32'd1);
    check("full_stable_rob", 32'(rs_if.issueROB), 32'd0);
    rs_if.issueReady = 1'b1;
    tick();
    check("full_drop", 32'(rs_if.ALUFull), 32'd0);
    check("full_first_rob", 32'(rs_if.issueROB), 32'(first_rob));
    rs_if.issueReady = 1'b0;
    tick();
    check("full_sixth_taken", 32'(rs_if.ALUFull), 32'd1);
    rs_if.stationRequest = 1'b0;
    rs_if.issueReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain%0d_valid", k), 32'(rs_if.issueValid), 32'd1);
      check($sformatf("drain%0d_rob", k), 32'(rs_if.issueROB), 32'(drain[k]));
      check($sformatf("drain%0d_op1", k), rs_if.issueOp1, 32'(drain[k]) + 32'd10);
    end
    tick();
    check("drain_done", 32'(rs_if.issueValid), 32'd0);

    // Flush with concurrent accept and wakeup
    rs_if.issueReady = 1'b0;
    req(1'b1, 1'b0, 3'd1, 3'd0, 32'd0, 32'd0, 4'h0, 3'd0);
    tick();
    for (int i = 1; i < 4; i++) begin
      req(1'b0, 1'b0, 3'd0, 3'd0, 32'(i), 32'd0, 4'h0, 3'(i));
      tick();
    end
    check("pre_flush_valid", 32'(rs_if.issueValid), 32'd1);
    check("pre_flush_count", 32'(dut.count_q), 32'd3);
    flush = 1'b1;
    req(1'b0, 1'b0, 3'd0, 3'd0, 32'd99, 32'd0, 4'h0, 3'd7);
    cdb(1'b1, 3'd1, 32'h44);
    tick();
    flush = 1'b0;
    rs_if.stationRequest = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    check("flush_valid", 32'(rs_if.issueValid), 32'd0);
    check("flush_full", 32'(rs_if.ALUFull), 32'd0);
    check("flush_count", 32'(dut.count_q), 32'd0);
    rs_if.issueReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("flush_quiet%0d", k), 32'(rs_if.issueValid), 32'd0);
    end

    // Selection: wake entry 2, then entry 0 a cycle later
    req(1'b1, 1'b0, 3'd1, 3'd0, 32'd0, 32'd0, 4'h0, 3'd5);
    tick();
    req(1'b1, 1'b0, 3'd7, 3'd0, 32'd0, 32'd0, 4'h0, 3'd6);
    tick();
    req(1'b1, 1'b0, 3'd5, 3'd0, 32'd0, 32'd0, 4'h0, 3'd7);
    tick();
    rs_if.stationRequest = 1'b0;
    cdb(1'b1, 3'd5, 32'h55);
    tick();
    check("sel1_none", 32'(rs_if.issueValid), 32'd0);
    cdb(1'b1, 3'd1, 32'h11);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    check("sel1_first_rob", 32'(rs_if.issueROB), 32'd7);
    check("sel1_first_op1", rs_if.issueOp1, 32'h55);
    tick();
    check("sel1_second_rob", 32'(rs_if.issueROB), 32'd5);
    check("sel1_second_op1", rs_if.issueOp1, 32'h11);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Selection: simultaneous wake, older entry sits at the higher index
    req(1'b1, 1'b0, 3'd3, 3'd0, 32'd0, 32'd0, 4'h0, 3'd1);
    tick();
    req(1'b1, 1'b0, 3'd7, 3'd0, 32'd0, 32'd0, 4'h0, 3'd2);
    tick();
    req(1'b1, 1'b0, 3'd1, 3'd0, 32'd0, 32'd0, 4'h0, 3'd3);
    tick();
    rs_if.stationRequest = 1'b0;
    cdb(1'b1, 3'd3, 32'h33);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    tick();
    check("sel2_p_rob", 32'(rs_if.issueROB), 32'd1);
    req(1'b1, 1'b0, 3'd1, 3'd0, 32'd0, 32'd0, 4'h0, 3'd4);
    tick();
    rs_if.stationRequest = 1'b0;
    check("sel2_idle", 32'(rs_if.issueValid), 32'd0);
    cdb(1'b1, 3'd1, 32'h11);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    tick();
`ifdef RS_AGE_SELECT_EN
    check("sel2_first_rob", 32'(rs_if.issueROB), 32'd3);
    tick();
    check("sel2_second_rob", 32'(rs_if.issueROB), 32'd4);
`else
    check("sel2_first_rob", 32'(rs_if.issueROB), 32'd4);
    tick();
    check("sel2_second_rob", 32'(rs_if.issueROB), 32'd3);
`endif
    check("sel2_second_valid", 32'(rs_if.issueValid), 32'd1);
    tick();
    check("sel2_empty", 32'(rs_if.issueValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
